// File: rtl/sort_vis_pkg.sv
// Shared definitions for the sorting visualisation engines and their pixel renderers.
package sort_vis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sort_state_e;

  // One automatic step per second at the 100 MHz system clock.
  localparam int unsigned STEP_DELAY_DEFAULT = 100_000_000;

  // RGB565 colours the renderers use for bars, the compared pair and the sorted region.
  localparam logic [15:0] COL_BG     = 16'h0000;
  localparam logic [15:0] COL_BAR    = 16'hFFFF;
  localparam logic [15:0] COL_CMP    = 16'hF800;
  localparam logic [15:0] COL_SWAP   = 16'hFFE0;
  localparam logic [15:0] COL_SORTED = 16'h07E0;

endpackage

// File: rtl/sort_step_engine_if.sv
// Control/status bundle between a sort engine and its controller/renderer.
interface sort_step_engine_if #(
  parameter int unsigned N_ELEM = 8,
  parameter int unsigned DATA_W = 7,
  parameter int unsigned IDX_W  = $clog2(N_ELEM)
);
  logic                     load;
  logic [N_ELEM*DATA_W-1:0] load_data;
  logic                     start;
  logic                     pause_tgl;
  logic                     step;
  logic                     descending;
  logic                     early_exit;
  logic [N_ELEM*DATA_W-1:0] elem_flat;
  logic [IDX_W-1:0]         cmp_idx;
  logic                     cmp_valid;
  logic                     swap_pulse;
  logic [IDX_W:0]           sorted_base;
  logic                     busy;
  logic                     paused;
  logic                     done;
  logic [15:0]              swap_cnt;

  modport master (
    output load, load_data, start, pause_tgl, step, descending, early_exit,
    input  elem_flat, cmp_idx, cmp_valid, swap_pulse, sorted_base, busy, paused, done, swap_cnt
  );

  modport slave (
    input  load, load_data, start, pause_tgl, step, descending, early_exit,
    output elem_flat, cmp_idx, cmp_valid, swap_pulse, sorted_base, busy, paused, done, swap_cnt
  );
endinterface

// File: rtl/step_pacer.sv
// Step delay counter: counts 0..STEP_DELAY-1 while run is high, holds otherwise,
// and ticks on the terminal count before wrapping to zero.
module step_pacer #(
  parameter int unsigned STEP_DELAY = 1,
  parameter int unsigned CNT_W      = $clog2(STEP_DELAY + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_DELAY - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = run && (cnt_q == TERM);
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sort_step_engine.sv
// Bubble-sort engine: one compare/swap per step, paced by step_pacer, with
// run/pause/single-step control and array/cursor state exported for rendering.
module sort_step_engine
  import sort_vis_pkg::*;
#(
  parameter int unsigned N_ELEM     = 8,
  parameter int unsigned DATA_W     = 7,
  parameter int unsigned STEP_DELAY = STEP_DELAY_DEFAULT,
  parameter int unsigned IDX_W      = $clog2(N_ELEM)
) (
  input logic               clk,
  input logic               rst_n,
  sort_step_engine_if.slave sif
);
  localparam logic [IDX_W:0]   SB_INIT   = (IDX_W + 1)'(N_ELEM);
  localparam logic [IDX_W:0]   LAST_IDX  = (IDX_W + 1)'(N_ELEM - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N_ELEM - 2);

  sort_state_e                  state_q, state_d;
  logic [N_ELEM-1:0][DATA_W-1:0] elem_q, elem_d;
  logic [IDX_W-1:0]             j_q, j_d;
  logic [IDX_W-1:0]             i_q, i_d;
  logic [IDX_W:0]               sorted_base_q, sorted_base_d;
  logic                         swap_pulse_q, swap_pulse_d;
  logic [15:0]                  swap_cnt_q, swap_cnt_d;
  logic                         pass_swapped_q, pass_swapped_d;
  logic                         desc_q, desc_d;
  logic                         early_exit_q, early_exit_d;

  logic                         pacer_clr, pacer_tick, step_go;
  logic [IDX_W-1:0]             j_nxt;
  logic [IDX_W:0]               pass_end;
  logic [DATA_W-1:0]            elem_a, elem_b;
  logic                         do_swap;

  assign pacer_clr = sif.load || ((state_q == ST_IDLE) && sif.start);

  step_pacer #(
    .STEP_DELAY (STEP_DELAY)
  ) u_pacer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pacer_clr),
    .run   (state_q == ST_RUN),
    .tick  (pacer_tick)
  );

  // pause_tgl beats a simultaneous manual step; an automatic tick still fires with it.
  assign step_go = ((state_q == ST_RUN) && pacer_tick) ||
                   ((state_q == ST_PAUSE) && sif.step && !sif.pause_tgl);

  assign j_nxt    = j_q + IDX_W'(1);
  assign pass_end = LAST_IDX - {1'b0, i_q};
  assign elem_a   = elem_q[j_q];
  assign elem_b   = elem_q[j_nxt];
  assign do_swap  = desc_q ? (elem_a < elem_b) : (elem_a > elem_b);

  always_comb begin
    state_d        = state_q;
    elem_d         = elem_q;
    j_d            = j_q;
    i_d            = i_q;
    sorted_base_d  = sorted_base_q;
    swap_pulse_d   = 1'b0;
    swap_cnt_d     = swap_cnt_q;
    pass_swapped_d = pass_swapped_q;
    desc_d         = desc_q;
    early_exit_d   = early_exit_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sif.start) begin
          state_d        = ST_RUN;
          j_d            = '0;
          i_d            = '0;
          swap_cnt_d     = '0;
          pass_swapped_d = 1'b0;
          desc_d         = sif.descending;
          early_exit_d   = sif.early_exit;
        end
      end
      ST_RUN:   if (sif.pause_tgl) state_d = ST_PAUSE;
      ST_PAUSE: if (sif.pause_tgl) state_d = ST_RUN;
      ST_DONE:  ;
      default:  state_d = ST_IDLE;
    endcase

    // The step is applied after the pause toggle so a finishing step can still land in DONE.
    if (step_go) begin
      if ({1'b0, j_q} < pass_end) begin
        if (do_swap) begin
          elem_d[j_q]    = elem_b;
          elem_d[j_nxt]  = elem_a;
          swap_pulse_d   = 1'b1;
          pass_swapped_d = 1'b1;
          if (swap_cnt_q != '1) swap_cnt_d = swap_cnt_q + 16'd1;
        end
        j_d = j_nxt;
      end else begin
        sorted_base_d = pass_end;
        if ((i_q == LAST_PASS) || (early_exit_q && !pass_swapped_q)) begin
          state_d       = ST_DONE;
          sorted_base_d = '0;
        end else begin
          i_d            = i_q + IDX_W'(1);
          j_d            = '0;
          pass_swapped_d = 1'b0;
        end
      end
    end

    if (sif.load) begin
      state_d        = ST_IDLE;
      elem_d         = sif.load_data;
      j_d            = '0;
      i_d            = '0;
      sorted_base_d  = SB_INIT;
      swap_pulse_d   = 1'b0;
      swap_cnt_d     = '0;
      pass_swapped_d = 1'b0;
      desc_d         = 1'b0;
      early_exit_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      elem_q         <= '0;
      j_q            <= '0;
      i_q            <= '0;
      sorted_base_q  <= SB_INIT;
      swap_pulse_q   <= 1'b0;
      swap_cnt_q     <= '0;
      pass_swapped_q <= 1'b0;
      desc_q         <= 1'b0;
      early_exit_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      elem_q         <= elem_d;
      j_q            <= j_d;
      i_q            <= i_d;
      sorted_base_q  <= sorted_base_d;
      swap_pulse_q   <= swap_pulse_d;
      swap_cnt_q     <= swap_cnt_d;
      pass_swapped_q <= pass_swapped_d;
      desc_q         <= desc_d;
      early_exit_q   <= early_exit_d;
    end
  end

  assign sif.elem_flat   = elem_q;
  assign sif.cmp_idx     = j_q;
  assign sif.cmp_valid   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign sif.busy        = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign sif.paused      = (state_q == ST_PAUSE);
  assign sif.done        = (state_q == ST_DONE);
  assign sif.swap_pulse  = swap_pulse_q;
  assign sif.sorted_base = sorted_base_q;
  assign sif.swap_cnt    = swap_cnt_q;
endmodule

// File: tb/tb_sort_step_engine.sv
// Scoreboard bench for sort_step_engine: expected swap snapshots and final results come
// from a bubble-sort reference model; a negedge monitor checks them as the DUT emits them.
module tb_sort_step_engine;
  localparam int N = 5;
  localparam int W = 7;
  localparam int D = 4;

  typedef logic [N-1:0][W-1:0] arr_t;
  typedef logic [N*W-1:0]      flat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_step_engine_if #(.N_ELEM(N), .DATA_W(W)) sif ();

  sort_step_engine #(
    .N_ELEM     (N),
    .DATA_W     (W),
    .STEP_DELAY (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  flat_t       exp_swap_arr[$];
  logic [15:0] exp_swap_cnt[$];
  flat_t       exp_done_arr[$];
  logic [15:0] exp_done_cnt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic arr_t mk5(input int v0, input int v1, input int v2, input int v3, input int v4);
    arr_t a;
    a[0] = W'(v0); a[1] = W'(v1); a[2] = W'(v2); a[3] = W'(v3); a[4] = W'(v4);
    return a;
  endfunction

  // Reference bubble sort: records the array after every swap and the total step count.
  task automatic model(input arr_t init, input bit desc, input bit ee, output int steps);
    arr_t        a;
    logic [W-1:0] t;
    int          sw;
    bit          fin;
    bit          any;
    a = init; sw = 0; steps = 0; fin = 1'b0;
    for (int i = 0; i < N - 1 && !fin; i++) begin
      any = 1'b0;
      for (int j = 0; j < N - 1 - i; j++) begin
        steps++;
        if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
          sw++;
          any = 1'b1;
          exp_swap_arr.push_back(a);
          exp_swap_cnt.push_back(16'(sw));
        end
      end
      steps++;
      if (ee && !any) fin = 1'b1;
    end
    exp_done_arr.push_back(a);
    exp_done_cnt.push_back(16'(sw));
  endtask

  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.swap_pulse) begin
        if (exp_swap_arr.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_swap: got swap_pulse with array %0h, expected none", sif.elem_flat);
        end else begin
          chk("swap_array", sif.elem_flat, exp_swap_arr.pop_front());
          chk("swap_count", sif.swap_cnt, exp_swap_cnt.pop_front());
        end
      end
      if (sif.done && !done_prev) begin
        if (exp_done_arr.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done, expected none");
        end else begin
          chk("done_array", sif.elem_flat, exp_done_arr.pop_front());
          chk("done_swap_cnt", sif.swap_cnt, exp_done_cnt.pop_front());
          chk("done_sorted_base", sif.sorted_base, 0);
          chk("done_cmp_valid", sif.cmp_valid, 0);
        end
      end
    end
    done_prev = rst_n ? sif.done : 1'b0;
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush_sb();
    exp_swap_arr.delete(); exp_swap_cnt.delete();
    exp_done_arr.delete(); exp_done_cnt.delete();
  endtask

  task automatic do_load(input arr_t v);
    sif.load_data = v;
    sif.load = 1'b1;
    tick_n(1);
    sif.load = 1'b0;
    flush_sb();
  endtask

  task automatic pulse_start();   sif.start = 1'b1;     tick_n(1); sif.start = 1'b0;     endtask
  task automatic pulse_pause();   sif.pause_tgl = 1'b1; tick_n(1); sif.pause_tgl = 1'b0; endtask
  task automatic pulse_step();    sif.step = 1'b1;      tick_n(1); sif.step = 1'b0;      endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!sif.done && cyc < limit) begin
      tick_n(1);
      cyc++;
    end
  endtask

  // Load, predict, start, then scramble the mode inputs to confirm they were latched.
  task automatic run_sort(input arr_t v, input bit desc, input bit ee, output int cyc);
    int steps;
    do_load(v);
    chk("load_array", sif.elem_flat, v);
    model(v, desc, ee, steps);
    sif.descending = desc;
    sif.early_exit = ee;
    pulse_start();
    sif.descending = ~desc;
    sif.early_exit = ~ee;
    wait_done(2000, cyc);
    chk("done_latency", cyc, steps * D);
    chk("busy_after_done", sif.busy, 0);
  endtask

  initial begin
    int   cyc;
    int   steps;
    arr_t v;
    sif.load = 1'b0; sif.load_data = '0; sif.start = 1'b0; sif.pause_tgl = 1'b0;
    sif.step = 1'b0; sif.descending = 1'b0; sif.early_exit = 1'b0;

    #12;
    chk("rst_elem", sif.elem_flat, 0);
    chk("rst_cmp_idx", sif.cmp_idx, 0);
    chk("rst_cmp_valid", sif.cmp_valid, 0);
    chk("rst_sorted_base", sif.sorted_base, N);
    chk("rst_flags", {sif.busy, sif.paused, sif.done, sif.swap_pulse}, 0);
    chk("rst_swap_cnt", sif.swap_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    tick_n(1);

    run_sort(mk5(5, 4, 3, 2, 1), 1'b0, 1'b0, cyc);
    chk("rev_asc_result", sif.elem_flat, mk5(1, 2, 3, 4, 5));
    chk("rev_asc_swaps", sif.swap_cnt, 10);

    run_sort(mk5(5, 4, 3, 2, 1), 1'b1, 1'b0, cyc);
    chk("rev_desc_swaps", sif.swap_cnt, 0);

    run_sort(mk5(5, 4, 3, 2, 1), 1'b1, 1'b1, cyc);
    chk("early_exit_latency", cyc, 5 * D);

    run_sort(mk5(3, 3, 1, 4, 4), 1'b0, 1'b0, cyc);
    chk("dup_result", sif.elem_flat, mk5(1, 3, 3, 4, 4));

    // DONE ignores control pulses other than load.
    pulse_start(); pulse_step(); pulse_pause();
    tick_n(2 * D);
    chk("done_holds", sif.done, 1);
    chk("done_holds_array", sif.elem_flat, mk5(1, 3, 3, 4, 4));

    // Pause after the first swap, single-step three times, then toggle+step together.
    do_load(mk5(5, 4, 3, 2, 1));
    model(mk5(5, 4, 3, 2, 1), 1'b0, 1'b0, steps);
    sif.descending = 1'b0; sif.early_exit = 1'b0;
    pulse_start();
    cyc = 0;
    while (!sif.swap_pulse && cyc < 100) begin tick_n(1); cyc++; end
    chk("first_swap_seen", sif.swap_pulse, 1);
    pulse_pause();
    chk("paused_flag", sif.paused, 1);
    chk("paused_cmp_idx", sif.cmp_idx, 1);
    tick_n(20);
    chk("no_auto_step_idx", sif.cmp_idx, 1);
    chk("still_paused", sif.paused, 1);
    for (int k = 0; k < 3; k++) begin
      pulse_step();
      chk("single_step_idx", sif.cmp_idx, 32'(k + 2));
      tick_n(2);
    end
    sif.step = 1'b1; sif.pause_tgl = 1'b1;
    tick_n(1);
    sif.step = 1'b0; sif.pause_tgl = 1'b0;
    chk("tgl_beats_step_idx", sif.cmp_idx, 4);
    chk("tgl_resumes", {sif.busy, sif.paused}, 2'b10);
    wait_done(500, cyc);
    chk("pause_run_done", sif.done, 1);

    // Abort with load during pass 2.
    do_load(mk5(5, 4, 3, 2, 1));
    model(mk5(5, 4, 3, 2, 1), 1'b0, 1'b0, steps);
    pulse_start();
    cyc = 0;
    while (sif.sorted_base != (N - 2) && cyc < 500) begin tick_n(1); cyc++; end
    chk("reached_pass2", sif.sorted_base, N - 2);
    v = mk5(9, 17, 2, 100, 64);
    do_load(v);
    chk("abort_flags", {sif.busy, sif.paused, sif.done, sif.cmp_valid}, 0);
    chk("abort_sorted_base", sif.sorted_base, N);
    chk("abort_array", sif.elem_flat, v);
    chk("abort_swap_cnt", sif.swap_cnt, 0);
    tick_n(20);
    chk("idle_no_steps", sif.elem_flat, v);

    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < N; k++) v[k] = W'($urandom_range(0, (r % 2) ? 127 : 7));
      run_sort(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cyc);
    end

    // Asynchronous reset mid-sort, asserted between clock edges.
    v = mk5(40, 30, 20, 10, 0);
    do_load(v);
    model(v, 1'b0, 1'b0, steps);
    pulse_start();
    tick_n(3 * D + 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_elem", sif.elem_flat, 0);
    chk("arst_cmp_idx", sif.cmp_idx, 0);
    chk("arst_sorted_base", sif.sorted_base, N);
    chk("arst_flags", {sif.busy, sif.paused, sif.done, sif.swap_pulse, sif.cmp_valid}, 0);
    chk("arst_swap_cnt", sif.swap_cnt, 0);
    flush_sb();
    @(negedge clk) rst_n = 1'b1;
    tick_n(2);
    chk("post_rst_idle", sif.busy, 0);

    chk("scoreboard_drained", 64'(exp_swap_arr.size() + exp_done_arr.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
